fdiv_meter: RTL and testbench

- Measures a divided or fractional-divided clock, e.g. a 9-to-2 (divide-by-4.5) output, in units of the fast clock clk.
- Sums clk cycles across EDGES consecutive rising-edge intervals of sig_in, so fractional ratios are resolved. Example: 9 cycles over 2 periods means 4.5.
- Sits beside the dividers as a self-check and characterisation block.
- Start/done handshake; results are held until the next measurement.

---
 rtl/fdiv_pkg.sv | 28 ++
 rtl/fdiv_sync_edge.sv | 29 ++
 rtl/fdiv_meter.sv | 170 +++++++++++++++++
 tb/tb_fdiv_meter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fdiv_pkg.sv
// Shared types and helpers for the fractional-divider period meter.
`timescale 1ns/1ps
package fdiv_pkg;

    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_EDGES       = 2;
    localparam int unsigned DEF_TIMEOUT     = 1023;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Widest counter the saturating helper supports.
    localparam int unsigned SAT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS,
        DONE
    } state_t;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] val,
        input logic [SAT_W-1:0] max_val
    );
        return (val >= max_val) ? max_val : val + SAT_W'(1);
    endfunction

endpackage

// File: rtl/fdiv_sync_edge.sv
// Multi-flop synchroniser for the clock under test plus a rising-edge detector.
`timescale 1ns/1ps
module fdiv_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic sig_in,
    output logic s_sync,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              s_prev;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig_in};
            s_prev <= sync_q[STAGES-1];
        end
    end

    assign s_sync = sync_q[STAGES-1];
    assign rise   = s_sync & ~s_prev;

endmodule

// File: rtl/fdiv_meter.sv
// Accumulates clk cycles over EDGES rising-edge intervals of a divided clock.
// Optional duty measurement (high_sum port) enabled by FDIV_METER_DUTY_MEAS_EN.
`timescale 1ns/1ps
module fdiv_meter
    import fdiv_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned EDGES       = DEF_EDGES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             sig_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period_sum,
    output logic             timeout_err,
    output logic             ovf_err
`ifdef FDIV_METER_DUTY_MEAS_EN
    ,
    output logic [CNT_W-1:0] high_sum
`endif
);

    localparam int unsigned      EW       = (EDGES < 2) ? 1 : $clog2(EDGES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [EW-1:0]    EDGE_END = EW'(EDGES - 1);

    state_t           state;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] gap;
    logic [EW-1:0]    edge_cnt;
    logic             rise;

    logic [CNT_W-1:0] acc_inc;
    logic [CNT_W-1:0] gap_inc;
    logic             acc_sat;
    logic             timeout_hit;
    logic             last_edge;

`ifdef FDIV_METER_DUTY_MEAS_EN
    logic             s_sync;
    logic [CNT_W-1:0] high_acc;
    logic [CNT_W-1:0] high_inc;
    logic             high_sat;
`else
    logic             unused_s_sync;
`endif

    fdiv_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .clr    (clr),
        .sig_in (sig_in),
`ifdef FDIV_METER_DUTY_MEAS_EN
        .s_sync (s_sync),
`else
        .s_sync (unused_s_sync),
`endif
        .rise   (rise)
    );

    // Counter arithmetic shared by the state machine.
    assign acc_inc     = CNT_W'(sat_inc(SAT_W'(acc), SAT_W'(CNT_MAX)));
    assign acc_sat     = (acc == CNT_MAX);
    assign gap_inc     = gap + CNT_W'(1);
    assign timeout_hit = (gap == GAP_LAST);
    assign last_edge   = (edge_cnt == EDGE_END);

`ifdef FDIV_METER_DUTY_MEAS_EN
    assign high_inc = CNT_W'(sat_inc(SAT_W'(high_acc), SAT_W'(CNT_MAX)));
    assign high_sat = (high_acc == CNT_MAX);
`endif

    // Measurement sequencer; a rise always wins over a coincident timeout.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            period_sum  <= '0;
            timeout_err <= 1'b0;
            ovf_err     <= 1'b0;
            acc         <= '0;
            gap         <= '0;
            edge_cnt    <= '0;
`ifdef FDIV_METER_DUTY_MEAS_EN
            high_acc    <= '0;
            high_sum    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc         <= '0;
                        gap         <= '0;
                        edge_cnt    <= '0;
                        timeout_err <= 1'b0;
                        ovf_err     <= 1'b0;
`ifdef FDIV_METER_DUTY_MEAS_EN
                        high_acc    <= '0;
                        high_sum    <= '0;
`endif
                        busy        <= 1'b1;
                        state       <= ARM;
                    end
                end
                ARM: begin
                    if (rise) begin
                        gap      <= '0;
                        edge_cnt <= '0;
                        state    <= MEAS;
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end else begin
                        gap <= gap_inc;
                    end
                end
                MEAS: begin
                    acc <= acc_inc;
                    if (acc_sat) begin
                        ovf_err <= 1'b1;
                    end
`ifdef FDIV_METER_DUTY_MEAS_EN
                    if (s_sync) begin
                        high_acc <= high_inc;
                        if (high_sat) begin
                            ovf_err <= 1'b1;
                        end
                    end
`endif
                    if (rise) begin
                        gap      <= '0;
                        edge_cnt <= edge_cnt + EW'(1);
                        if (last_edge) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end else begin
                        gap <= gap_inc;
                    end
                end
                DONE: begin
                    done       <= 1'b1;
                    period_sum <= acc;
`ifdef FDIV_METER_DUTY_MEAS_EN
                    high_sum   <= high_acc;
`endif
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_meter.sv
// Directed, table-driven bench for fdiv_meter using three differently sized instances.
`timescale 1ns/1ps
module tb_fdiv_meter;

    logic        clk = 1'b0;
    logic        clr;
    logic        sig;
    logic [2:0]  start_w;
    logic [2:0]  busy_w, done_w, to_w, ovf_w;
    logic [15:0] sum_a, sum_b;
    logic [3:0]  sum_c;
`ifdef FDIV_METER_DUTY_MEAS_EN
    logic [15:0] high_a, high_b;
    logic [3:0]  high_c;
`endif

    int errors = 0;
    int checks = 0;
    int mode   = 0;
    int ph     = 0;

    always #5 clk = ~clk;

    // a: EDGES=2, b: EDGES=4, c: 4-bit counters for saturation
    fdiv_meter #(.CNT_W(16), .EDGES(2), .TIMEOUT(20), .SYNC_STAGES(2)) u_a (
        .clk(clk), .clr(clr), .start(start_w[0]), .sig_in(sig),
        .busy(busy_w[0]), .done(done_w[0]), .period_sum(sum_a),
        .timeout_err(to_w[0]), .ovf_err(ovf_w[0])
`ifdef FDIV_METER_DUTY_MEAS_EN
        , .high_sum(high_a)
`endif
    );

    fdiv_meter #(.CNT_W(16), .EDGES(4), .TIMEOUT(20), .SYNC_STAGES(3)) u_b (
        .clk(clk), .clr(clr), .start(start_w[1]), .sig_in(sig),
        .busy(busy_w[1]), .done(done_w[1]), .period_sum(sum_b),
        .timeout_err(to_w[1]), .ovf_err(ovf_w[1])
`ifdef FDIV_METER_DUTY_MEAS_EN
        , .high_sum(high_b)
`endif
    );

    fdiv_meter #(.CNT_W(4), .EDGES(2), .TIMEOUT(15), .SYNC_STAGES(2)) u_c (
        .clk(clk), .clr(clr), .start(start_w[2]), .sig_in(sig),
        .busy(busy_w[2]), .done(done_w[2]), .period_sum(sum_c),
        .timeout_err(to_w[2]), .ovf_err(ovf_w[2])
`ifdef FDIV_METER_DUTY_MEAS_EN
        , .high_sum(high_c)
`endif
    );

    // Divided-clock patterns: 0 idle low, 1 period 9 (4 high), 2 gaps 4/5, 3 period 14 (7 high)
    initial begin
        sig = 1'b0;
        forever begin
            @(negedge clk);
            case (mode)
                1:       sig = ((ph % 9) < 4);
                2:       sig = ((ph % 9) == 0) || ((ph % 9) == 1) || ((ph % 9) == 4) || ((ph % 9) == 5);
                3:       sig = ((ph % 14) < 7);
                default: sig = 1'b0;
            endcase
            ph = ph + 1;
        end
    end

    typedef struct {
        int unit;
        int mode;
        int sum;
        int to;
        int ovf;
        int high;
        int lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [31:0] sum_of(input int u);
        case (u)
            0:       return 32'(sum_a);
            1:       return 32'(sum_b);
            default: return 32'(sum_c);
        endcase
    endfunction

`ifdef FDIV_METER_DUTY_MEAS_EN
    function automatic logic [31:0] high_of(input int u);
        case (u)
            0:       return 32'(high_a);
            1:       return 32'(high_b);
            default: return 32'(high_c);
        endcase
    endfunction
`endif

    // Start one measurement on unit u and wait (bounded) for its done pulse.
    task automatic run(input int u, input int m, output int lat, output bit got_done);
        mode = m;
        repeat (20) @(posedge clk);
        #1 start_w[u] = 1'b1;
        @(posedge clk);
        #1 start_w[u] = 1'b0;
        check($sformatf("u%0d_busy_after_start", u), 32'(busy_w[u]), 32'd1);
        lat      = 0;
        got_done = 1'b0;
        for (int n = 1; n <= 300 && !got_done; n++) begin
            @(posedge clk);
            #1;
            if (done_w[u]) begin
                got_done = 1'b1;
                lat      = n;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  gd;
        int  dones;
        int  busy_after;
        bit  prev_busy;

        vecs[0] = '{0, 1, 18, 0, 0,  8,  0};
        vecs[1] = '{0, 2,  9, 0, 0, -1,  0};
        vecs[2] = '{1, 2, 18, 0, 0, -1,  0};
        vecs[3] = '{1, 1, 36, 0, 0, 16,  0};
        vecs[4] = '{0, 0,  0, 1, 0,  0, 21};
        vecs[5] = '{2, 3, 15, 0, 1, 14,  0};
        vecs[6] = '{2, 1, 15, 0, 1,  8,  0};
        vecs[7] = '{1, 0,  0, 1, 0,  0, 21};
        vecs[8] = '{2, 0,  0, 1, 0,  0, 16};
        vecs[9] = '{0, 3, 28, 0, 0, 14,  0};

        start_w = 3'b000;
        clr     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d_reset_flags", u),
                  32'({busy_w[u], done_w[u], to_w[u], ovf_w[u]}), 32'd0);
            check($sformatf("u%0d_reset_sum", u), sum_of(u), 32'd0);
        end
        clr = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].unit, vecs[i].mode, lat, gd);
            check($sformatf("v%0d_done_seen", i), 32'(gd), 32'd1);
            if (gd) begin
                check($sformatf("v%0d_period_sum", i), sum_of(vecs[i].unit), 32'(vecs[i].sum));
                check($sformatf("v%0d_timeout_err", i), 32'(to_w[vecs[i].unit]), 32'(vecs[i].to));
                check($sformatf("v%0d_ovf_err", i), 32'(ovf_w[vecs[i].unit]), 32'(vecs[i].ovf));
                if (vecs[i].lat > 0)
                    check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
`ifdef FDIV_METER_DUTY_MEAS_EN
                if (vecs[i].high >= 0)
                    check($sformatf("v%0d_high_sum", i), high_of(vecs[i].unit), 32'(vecs[i].high));
`endif
                @(posedge clk);
                #1;
                check($sformatf("v%0d_done_one_cycle", i), 32'(done_w[vecs[i].unit]), 32'd0);
                check($sformatf("v%0d_sum_held", i), sum_of(vecs[i].unit), 32'(vecs[i].sum));
            end
        end

        // Asynchronous clear in the middle of a measurement on unit a.
        mode = 1;
        repeat (20) @(posedge clk);
        #1 start_w[0] = 1'b1;
        @(posedge clk);
        #1 start_w[0] = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("clr_pre_busy", 32'(busy_w[0]), 32'd1);
        #2 clr = 1'b1;
        #1;
        check("clr_flags_zero", 32'({busy_w[0], done_w[0], to_w[0], ovf_w[0]}), 32'd0);
        check("clr_sum_zero", sum_of(0), 32'd0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        dones = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done_w != 3'b000) dones++;
        end
        check("clr_no_done", 32'(dones), 32'd0);
        run(0, 1, lat, gd);
        check("clr_fresh_done", 32'(gd), 32'd1);
        check("clr_fresh_sum", sum_of(0), 32'd18);
        check("clr_fresh_to", 32'(to_w[0]), 32'd0);

        // start spammed through ARM/MEAS and on the DONE cycle must be ignored.
        mode = 1;
        repeat (20) @(posedge clk);
        #1 start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        dones      = 0;
        busy_after = 0;
        prev_busy  = 1'b1;
        for (int n = 0; n < 120; n++) begin
            if (busy_w[0] && dones > 0) busy_after++;
            start_w[0] = (dones == 0) && (busy_w[0] || prev_busy);
            prev_busy  = busy_w[0];
            @(posedge clk);
            #1;
            if (done_w[0]) dones++;
        end
        start_w[0] = 1'b0;
        check("spam_one_done", 32'(dones), 32'd1);
        check("spam_no_restart", 32'(busy_after), 32'd0);
        check("spam_sum", sum_of(0), 32'd18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
